// File: rtl/reg_dest_pipe_if.sv
// Handshake/bus bundle for reg_dest_pipe: destination selection inputs,
// pipeline control, source addresses and the tracked-stage outputs.
interface reg_dest_pipe_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 3
);
    logic [1:0]        sel;
    logic [ADDR_W-1:0] in0;
    logic [ADDR_W-1:0] in1;
    logic [ADDR_W-1:0] in2;
    logic [ADDR_W-1:0] in3;
    logic              valid_in;
    logic              wr_en;
    logic              stall;
    logic              flush;
    logic [ADDR_W-1:0] src_a;
    logic [ADDR_W-1:0] src_b;
    logic [ADDR_W-1:0] dest_sel;
    logic [ADDR_W-1:0] dest_out;
    logic              wen_out;
    logic [DEPTH-1:0]  hazard_a;
    logic [DEPTH-1:0]  hazard_b;
    logic              busy;

    modport master (
        output sel, in0, in1, in2, in3, valid_in, wr_en, stall, flush, src_a, src_b,
        input  dest_sel, dest_out, wen_out, hazard_a, hazard_b, busy
    );

    modport slave (
        input  sel, in0, in1, in2, in3, valid_in, wr_en, stall, flush, src_a, src_b,
        output dest_sel, dest_out, wen_out, hazard_a, hazard_b, busy
    );
endinterface

// File: rtl/reg_dest_pipe.sv
// Destination-register selector plus DEPTH-stage tracker that raises per-stage
// hazard flags when an in-flight valid write matches src_a/src_b.
module reg_dest_pipe #(
    parameter int unsigned ADDR_W        = 5,
    parameter int unsigned DEPTH         = 3,
    parameter int unsigned CONST_A       = 31,
    parameter int unsigned CONST_B       = 29,
    parameter bit          EXT_MODE      = 1'b0,
    parameter bit          ZERO_SUPPRESS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    reg_dest_pipe_if.slave    bus
);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0]            dest_sel;
    logic                         v_new;
    logic                         src_a_zero, src_b_zero;
    logic [DEPTH-1:0]             haz_a, haz_b;

    always_comb begin
        dest_sel = '0;
        case (bus.sel)
            2'b00:   dest_sel = bus.in0;
            2'b01:   dest_sel = bus.in1;
            2'b10:   dest_sel = EXT_MODE ? bus.in2 : ADDR_W'(CONST_A);
            default: dest_sel = EXT_MODE ? bus.in3 : ADDR_W'(CONST_B);
        endcase
    end

    assign v_new = bus.valid_in & bus.wr_en & ~(ZERO_SUPPRESS & (dest_sel == '0));

    // Flush outranks stall; addresses are zeroed on flush so no stale value lingers.
    always_comb begin
        v_d    = v_q;
        addr_d = addr_q;
        if (bus.flush) begin
            v_d    = '0;
            addr_d = '0;
        end else if (!bus.stall) begin
            v_d[0]    = v_new;
            addr_d[0] = dest_sel;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                v_d[i]    = v_q[i-1];
                addr_d[i] = addr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            addr_q <= '0;
        end else begin
            v_q    <= v_d;
            addr_q <= addr_d;
        end
    end

    assign src_a_zero = ZERO_SUPPRESS & (bus.src_a == '0);
    assign src_b_zero = ZERO_SUPPRESS & (bus.src_b == '0);

    always_comb begin
        haz_a = '0;
        haz_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            haz_a[i] = v_q[i] & (addr_q[i] == bus.src_a) & ~src_a_zero;
            haz_b[i] = v_q[i] & (addr_q[i] == bus.src_b) & ~src_b_zero;
        end
    end

    assign bus.dest_sel = dest_sel;
    assign bus.dest_out = addr_q[DEPTH-1];
    assign bus.wen_out  = v_q[DEPTH-1];
    assign bus.hazard_a = haz_a;
    assign bus.hazard_b = haz_b;
    assign bus.busy     = |v_q;

endmodule

// File: doc/reg_dest_pipe.md
# reg_dest_pipe

Parametrised destination-register selector and tracker for the pipelined MIPS datapath. It picks the write-register address per instruction (rt, rd, or the fixed $ra/$sp constants, or two extra inputs in extended mode). It carries that address through DEPTH pipeline stages with stall and flush control, and it compares every in-flight destination against two source addresses to produce per-stage hazard flags for the forwarding and stall logic.

## Interface
- ADDR_W, 5, register address width
- DEPTH, 3, number of tracked stages (stage 0 = EX … stage DEPTH-1 = WB); legal 1–8
- CONST_A, 31, address driven for sel=2'b10 when EXT_MODE=0 ($ra)
- CONST_B, 29, address driven for sel=2'b11 when EXT_MODE=0 ($sp)
- EXT_MODE, 0, 1 = sel 2'b10/2'b11 route in2/in3 instead of the constants
- ZERO_SUPPRESS, 1, 1 = address 0 never writes and never raises a hazard
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- sel  in  2  destination select
- in0, in1, in2, in3  in  ADDR_W each  candidate addresses (in2/in3 ignored when EXT_MODE=0)
- valid_in  in  1  instruction present at the select stage this cycle
- wr_en  in  1  instruction writes the register file
- stall  in  1  hold all stages
- flush  in  1  invalidate all stages
- src_a, src_b  in  ADDR_W each  source addresses to check
- dest_sel  out  ADDR_W  combinational selected address
- dest_out  out  ADDR_W  address held in stage DEPTH-1
- wen_out  out  1  valid write in stage DEPTH-1
- hazard_a, hazard_b  out  DEPTH  bit i set when stage i holds a valid write matching src_a/src_b
- busy  out  1  OR of all stage valid bits

## Operation
- dest_sel: 00→in0, 01→in1, 10→CONST_A (or in2), 11→CONST_B (or in3). It is purely combinational and does not depend on reset.
- Each stage holds {v, addr}. The captured valid is v_new = valid_in & wr_en & ~(ZERO_SUPPRESS & dest_sel==0).
- Per rising edge, highest priority first:
  - reset: all v←0 and addr←0.
  - flush: all v←0; addr fields are don't-care and are cleared to 0.
  - stall: all stages hold; the incoming instruction is not captured.
  - otherwise: stage 0←{v_new, dest_sel}, stage i←stage i-1 for i≥1, and the stage DEPTH-1 contents are retired.
- hazard_a[i] = v[i] & (addr[i]==src_a) & ~(ZERO_SUPPRESS & src_a==0). hazard_b is defined the same way with src_b. Both are combinational from registered state and the src inputs.
- Simultaneous stall and flush: flush wins.
- flush with valid_in: the instruction is dropped.
- Several stages matching the same source: all matching bits are set, and consumer priority is left to the consumer.
- Flag values are unaffected by wen_out or retirement timing; a retiring stage still flags in its last cycle.

## Timing
- Reset values: dest_out=0, wen_out=0, hazard_a=hazard_b=0, busy=0. dest_sel follows its inputs.
- Latency from the select cycle to stage k is k+1 unstalled edges. wen_out asserts DEPTH edges after capture.
- Each stall cycle adds exactly one cycle of latency to every in-flight entry.
- Reset asserted mid-operation clears everything at that edge. No stale write survives.
- DEPTH=1: stage 0 is also the output stage.

## Test plan
- Select sweep, EXT_MODE=0: in0=8, in1=9, sel=00/01/10/11 → dest_sel=8, 9, 31, 29. With EXT_MODE=1 and in2=4, in3=5 → 4, 5.
- Propagation, DEPTH=3: capture sel=01 with in1=12, valid_in=wr_en=1 → hazard_a=3'b001/010/100 over the next 3 cycles with src_a=12. wen_out=1 and dest_out=12 in the third cycle after the edge.
- Stall and flush: two stall cycles in mid-flight → wen_out delayed by 2 cycles. Stall and flush together → busy=0 on the next cycle, no wen_out.
- Zero suppression: in0=0, sel=00, valid → v stays 0 and wen_out never asserts. src_a=0 gives hazard_a=0 even with ZERO_SUPPRESS=0 entries absent.
- Reset mid-flight: three valid writes in flight, then reset for 1 cycle → all outputs 0 on the following cycle, and no later wen_out.
